// File: rtl/parking_slot_manager_if.sv
// ---------------------------------------------------------------------------
// parking_slot_manager_if
// Request / status bundle between a parking-lot controller and its client.
//   entry_signal  : car requests entry (one request per asserted cycle)
//   exit_signal   : car requests exit from exit_slot
//   exit_slot     : bay being vacated
//   is_open       : barrier door open (level)
//   is_full       : no free bays (level)
//   entry_reject  : one-cycle pulse, entry refused because the lot was full
//   exit_error    : one-cycle pulse, exit refused (bay empty or out of range)
//   spots         : occupancy map, 1 = occupied
//   capacity      : free bay count
//   location      : lowest-index free bay
//   loc_valid     : location is meaningful (capacity != 0)
// Modports: master = client side (drives requests), slave = controller side.
// ---------------------------------------------------------------------------
interface parking_slot_manager_if #(
   parameter int SLOTS  = 8,
   parameter int SLOT_W = $clog2(SLOTS),
   parameter int CAP_W  = $clog2(SLOTS + 1)
);
   logic              entry_signal;
   logic              exit_signal;
   logic [SLOT_W-1:0] exit_slot;
   logic              is_open;
   logic              is_full;
   logic              entry_reject;
   logic              exit_error;
   logic [SLOTS-1:0]  spots;
   logic [CAP_W-1:0]  capacity;
   logic [SLOT_W-1:0] location;
   logic              loc_valid;

   modport master (
      output entry_signal, exit_signal, exit_slot,
      input  is_open, is_full, entry_reject, exit_error,
             spots, capacity, location, loc_valid
   );

   modport slave (
      input  entry_signal, exit_signal, exit_slot,
      output is_open, is_full, entry_reject, exit_error,
             spots, capacity, location, loc_valid
   );
endinterface

// File: rtl/parking_slot_manager.sv
// ---------------------------------------------------------------------------
// parking_slot_manager
// Tracks occupancy of SLOTS bays, grants the lowest-numbered free bay to each
// arriving car, frees a named bay on exit, and holds the barrier door open for
// DOOR_CYCLES cycles after the most recent granted event.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : parking_slot_manager_if.slave (requests in, registered status out)
// ---------------------------------------------------------------------------
module parking_slot_manager #(
   parameter int SLOTS       = 8,
   parameter int DOOR_CYCLES = 4,
   parameter int SLOT_W      = $clog2(SLOTS),
   parameter int CAP_W       = $clog2(SLOTS + 1)
) (
   input logic                    clk,
   input logic                    reset,
   parking_slot_manager_if.slave  bus
);

   typedef enum logic [0:0] {
      CLOSED = 1'b0,
      OPEN   = 1'b1
   } door_state_t;

   // Registered state / outputs
   logic [SLOTS-1:0]  spots_r;
   logic [CAP_W-1:0]  capacity_r;
   logic [SLOT_W-1:0] location_r;
   logic              loc_valid_r;
   logic              is_full_r;
   logic              entry_reject_r;
   logic              exit_error_r;
   door_state_t       state_r;
   logic [7:0]        timer_r;
   logic              is_open_r;

   // Next-state values
   logic [SLOTS-1:0]  spots_s;
   logic [CAP_W-1:0]  capacity_s;
   logic [SLOT_W-1:0] location_s;
   logic              loc_valid_s;
   logic              grant_s;
   logic              reject_s;
   logic              exit_ok_s;
   logic              exit_err_s;
   logic [CAP_W-1:0]  exit_ext_s;
   logic              in_range_s;
   door_state_t       state_s;
   logic [7:0]        timer_s;

   // Request classification against pre-edge state
   always_comb begin
      exit_ext_s = CAP_W'(bus.exit_slot);
      in_range_s = (exit_ext_s < CAP_W'(SLOTS));
      grant_s    = bus.entry_signal && (capacity_r != {CAP_W{1'b0}});
      reject_s   = bus.entry_signal && (capacity_r == {CAP_W{1'b0}});
      if (in_range_s) begin
         exit_ok_s = bus.exit_signal && spots_r[bus.exit_slot];
      end else begin
         exit_ok_s = 1'b0;
      end
      exit_err_s = bus.exit_signal && !exit_ok_s;
   end

   // Occupancy map update, capacity and lowest-free-bay priority encoder
   always_comb begin
      spots_s = spots_r;
      // location_r is guaranteed free whenever capacity is non-zero, and an
      // exiting bay is always occupied, so the two updates never collide.
      if (grant_s) begin
         spots_s[location_r] = 1'b1;
      end else begin
         spots_s = spots_s;
      end
      if (exit_ok_s) begin
         spots_s[bus.exit_slot] = 1'b0;
      end else begin
         spots_s = spots_s;
      end
      capacity_s = capacity_r - CAP_W'(grant_s) + CAP_W'(exit_ok_s);

      // Scan downward so the lowest free index wins.
      location_s  = {SLOT_W{1'b0}};
      loc_valid_s = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!spots_s[i]) begin
            location_s  = SLOT_W'(i);
            loc_valid_s = 1'b1;
         end else begin
            location_s  = location_s;
         end
      end
   end

   // Door FSM next-state: any granted event (re)loads the hold timer
   always_comb begin
      state_s = state_r;
      timer_s = timer_r;
      if (grant_s || exit_ok_s) begin
         state_s = OPEN;
         timer_s = 8'(DOOR_CYCLES);
      end else begin
         case (state_r)
            OPEN: begin
               if (timer_r == 8'd1) begin
                  state_s = CLOSED;
                  timer_s = 8'd0;
               end else begin
                  timer_s = timer_r - 8'd1;
               end
            end
            CLOSED: begin
               state_s = CLOSED;
               timer_s = 8'd0;
            end
            default: begin
               state_s = CLOSED;
               timer_s = 8'd0;
            end
         endcase
      end
   end

   // Door FSM state register; is_open is registered alongside the state
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= CLOSED;
         timer_r   <= 8'd0;
         is_open_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         timer_r   <= timer_s;
         is_open_r <= (state_s == OPEN);
      end
   end

   // Occupancy, pointer and pulse registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         spots_r        <= {SLOTS{1'b0}};
         capacity_r     <= CAP_W'(SLOTS);
         location_r     <= {SLOT_W{1'b0}};
         loc_valid_r    <= 1'b1;
         is_full_r      <= 1'b0;
         entry_reject_r <= 1'b0;
         exit_error_r   <= 1'b0;
      end else begin
         spots_r        <= spots_s;
         capacity_r     <= capacity_s;
         location_r     <= location_s;
         loc_valid_r    <= loc_valid_s;
         is_full_r      <= (capacity_s == {CAP_W{1'b0}});
         entry_reject_r <= reject_s;
         exit_error_r   <= exit_err_s;
      end
   end

   assign bus.spots        = spots_r;
   assign bus.capacity     = capacity_r;
   assign bus.location     = location_r;
   assign bus.loc_valid    = loc_valid_r;
   assign bus.is_full      = is_full_r;
   assign bus.entry_reject = entry_reject_r;
   assign bus.exit_error   = exit_error_r;
   assign bus.is_open      = is_open_r;

endmodule

// File: tb/tb_parking_slot_manager.sv
// ---------------------------------------------------------------------------
// tb_parking_slot_manager
// Scoreboard bench for parking_slot_manager (SLOTS = 4, DOOR_CYCLES = 3).
// The driver applies one request set per cycle, advances a reference model of
// the lot and pushes the expected post-edge outputs; a monitor pops one entry
// per cycle shortly after the rising edge and compares every output.
// ---------------------------------------------------------------------------
module tb_parking_slot_manager;
   localparam int SLOTS  = 4;
   localparam int DC     = 3;
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int CAP_W  = $clog2(SLOTS + 1);

   typedef struct {
      int spots;
      int cap;
      int loc;
      int lv;
      int full;
      int open;
      int rej;
      int err;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t sb[$];

   // Reference model state
   bit occ[SLOTS];
   int door_left;

   parking_slot_manager_if #(.SLOTS(SLOTS)) bus ();

   parking_slot_manager #(.SLOTS(SLOTS), .DOOR_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: advance one edge and produce expected outputs
   function automatic exp_t model_step(input bit e, input bit x, input int s, input bit r);
      exp_t ex;
      int   free_n;
      int   first;
      bit   opened;
      bit   x_ok;
      ex.rej = 0;
      ex.err = 0;
      if (!r) begin
         for (int i = 0; i < SLOTS; i++) occ[i] = 0;
         door_left = 0;
      end else begin
         free_n = 0;
         first  = -1;
         for (int i = 0; i < SLOTS; i++) begin
            if (!occ[i]) begin
               free_n++;
               if (first < 0) first = i;
            end
         end
         opened = 0;
         x_ok   = x && (s < SLOTS) && occ[s];
         if (e) begin
            if (free_n > 0) begin
               occ[first] = 1;
               opened = 1;
            end else ex.rej = 1;
         end
         if (x) begin
            if (x_ok) begin
               occ[s] = 0;
               opened = 1;
            end else ex.err = 1;
         end
         if (opened) door_left = DC;
         else if (door_left > 0) door_left--;
      end
      ex.spots = 0;
      ex.cap   = 0;
      ex.loc   = -1;
      for (int i = 0; i < SLOTS; i++) begin
         if (occ[i]) ex.spots += (1 << i);
         else begin
            ex.cap++;
            if (ex.loc < 0) ex.loc = i;
         end
      end
      if (ex.loc < 0) ex.loc = 0;
      ex.lv   = (ex.cap != 0);
      ex.full = (ex.cap == 0);
      ex.open = (door_left > 0);
      return ex;
   endfunction

   // Driver: one request set per cycle, expected response queued
   task automatic cyc(input bit e, input bit x, input int s, input bit r);
      @(negedge clk);
      reset            = r;
      bus.entry_signal = e;
      bus.exit_signal  = x;
      bus.exit_slot    = SLOT_W'(s);
      sb.push_back(model_step(e, x, s, r));
   endtask

   // Monitor: compare every output once per cycle after the edge
   always @(posedge clk) begin
      exp_t ex;
      #1;
      if (sb.size() > 0) begin
         ex = sb.pop_front();
         chk("spots",        int'(bus.spots),        ex.spots);
         chk("capacity",     int'(bus.capacity),     ex.cap);
         chk("location",     int'(bus.location),     ex.loc);
         chk("loc_valid",    int'(bus.loc_valid),    ex.lv);
         chk("is_full",      int'(bus.is_full),      ex.full);
         chk("is_open",      int'(bus.is_open),      ex.open);
         chk("entry_reject", int'(bus.entry_reject), ex.rej);
         chk("exit_error",   int'(bus.exit_error),   ex.err);
      end
   end

   initial begin
      int wait_n;
      checks           = 0;
      failures         = 0;
      door_left        = 0;
      reset            = 1'b0;
      bus.entry_signal = 1'b0;
      bus.exit_signal  = 1'b0;
      bus.exit_slot    = '0;

      // Reset, then fill the lot
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
      // Full lot: reject, door must not reopen
      cyc(1, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
      // Exit bay 1 from full, watch the 3-cycle hold
      cyc(0, 1, 1, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
      // Refill, then entry + exit bay 2 while full
      cyc(1, 0, 0, 1);
      cyc(1, 1, 2, 1);
      // Walk to 0101: 1011 -> 0011 -> 0001 -> 0011 -> 0111 -> 0101
      cyc(0, 1, 3, 1);
      cyc(0, 1, 1, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(0, 1, 1, 1);
      // Entry + exit bay 0 -> 0110
      cyc(1, 1, 0, 1);
      // Down to 0001, then exit empty bay 3
      cyc(0, 1, 1, 1);
      cyc(0, 1, 2, 1);
      cyc(1, 0, 0, 1);
      cyc(0, 1, 3, 1);
      // Reset during a door hold
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 400; n++) begin
         cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
             $urandom_range(0, SLOTS - 1), $urandom_range(0, 59) != 0);
      end
      cyc(0, 0, 0, 1);

      // Drain the scoreboard with a bounded wait
      wait_n = 0;
      while (sb.size() > 0 && wait_n < 10) begin
         @(negedge clk);
         wait_n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
